// File: rtl/mdb_mem_ctrl.sv
// Data-memory controller on the MDB: word/byte reads and writes against a word-wide RAM,
// with byte writes done as read-modify-write and a req/ready completion handshake.
module mdb_mem_ctrl #(
  parameter int          ADDR_W = 9,
  parameter logic [15:0] BASE   = 16'h0200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic        bw,
  input  logic [15:0] MAB,
  input  logic [15:0] MDB_in,
  output logic [15:0] MDB_out,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned SPAN = 2 ** (ADDR_W + 1);

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, DONE} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] idx_q;
  logic              lane_q;
  logic              we_q;
  logic              bw_q;
  logic              oor_q;
  logic [15:0]       data_q;
  logic [15:0]       rdata_q;
  logic [15:0]       mem [2**ADDR_W];

  // Unsigned 16-bit offset: addresses below BASE wrap to large values and fail the range test.
  logic [15:0] off;
  logic        in_range;

  assign off      = MAB - BASE;
  assign in_range = 32'(off) < SPAN;
  assign busy     = (state_q != IDLE);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (!in_range)     state_d = DONE;
          else if (we && !bw) state_d = WR;
          else               state_d = RD;
        end
      end
      RD:      state_d = we_q ? MRG : DONE;
      MRG:     state_d = WR;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      MDB_out <= 16'h0000;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      ready   <= (state_q == DONE);
      err     <= (state_q == DONE) && oor_q;
      if (state_q == DONE) begin
        if (oor_q)
          MDB_out <= 16'h0000;
        else if (!we_q)
          MDB_out <= bw_q ? {8'h00, (lane_q ? rdata_q[15:8] : rdata_q[7:0])} : rdata_q;
      end
    end
  end

  // Holding registers; the merged word replaces the captured data in MRG so WR always writes data_q.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) begin
      idx_q  <= off[ADDR_W:1];
      lane_q <= MAB[0];
      data_q <= MDB_in;
      we_q   <= we;
      bw_q   <= bw;
      oor_q  <= !in_range;
    end else if (state_q == MRG) begin
      data_q <= lane_q ? {data_q[7:0], rdata_q[7:0]} : {rdata_q[15:8], data_q[7:0]};
    end
  end

  // NOTE: the RAM array has no reset; only the write enable is gated by rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == WR)
      mem[idx_q] <= data_q;
    if (state_q == RD)
      rdata_q <= mem[idx_q];
  end

endmodule

// File: tb/tb_mdb_mem_ctrl.sv
// Scoreboard bench for mdb_mem_ctrl: the driver queues hand-computed responses, the monitor
// pops and compares them whenever ready pulses.
module tb_mdb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic        bw;
  logic [15:0] MAB;
  logic [15:0] MDB_in;
  logic [15:0] MDB_out;
  logic        ready;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
    int          c0;
    string       name;
  } exp_t;

  exp_t sb[$];

  mdb_mem_ctrl #(.ADDR_W(9), .BASE(16'h0200)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .we      (we),
    .bw      (bw),
    .MAB     (MAB),
    .MDB_in  (MDB_in),
    .MDB_out (MDB_out),
    .ready   (ready),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 32'(ready), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_data"}, 32'(MDB_out), 32'(e.data));
        check({e.name, "_err"},  32'(err),     32'(e.err));
        check({e.name, "_lat"},  32'(cyc - e.c0), 32'(e.lat));
      end
    end
  end

  // Caller must be at a negedge; returns at the negedge where ready is seen.
  task automatic issue(input string name, input logic w, input logic b, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] exp_d, input logic exp_e,
                       input int lat);
    exp_t e;
    bit   seen = 0;
    req = 1'b1; we = w; bw = b; MAB = a; MDB_in = d;
    @(posedge clk);
    @(negedge clk);
    e.data = exp_d; e.err = exp_e; e.lat = lat; e.c0 = cyc; e.name = name;
    sb.push_back(e);
    req = 1'b0; MAB = 16'hxxxx; MDB_in = 16'hxxxx;
    if (lat == 1) seen = 1'b0;
    for (int i = 1; i < 8 && !seen; i++) begin
      if (i > 1 || lat > 1) @(negedge clk);
      if (i == 1 && lat > 1) continue;
      seen = (ready === 1'b1);
    end
    if (!seen) begin
      check({name, "_timeout"}, 32'(ready), 32'd1);
      if (sb.size() > 0) void'(sb.pop_back());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; bw = 1'b0; MAB = 16'h0000; MDB_in = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready),   32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_err",   32'(err),     32'd0);
    check("rst_mdb",   32'(MDB_out), 32'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    //    name         we    bw    MAB       MDB_in    exp_out   err  lat
    issue("wr_beef",   1'b1, 1'b0, 16'h0200, 16'hBEEF, 16'h0000, 1'b0, 2);
    issue("rd_beef",   1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 1'b0, 2);
    issue("bwr_12",    1'b1, 1'b1, 16'h0201, 16'hFF12, 16'hBEEF, 1'b0, 4);
    issue("rd_merge",  1'b0, 1'b0, 16'h0200, 16'h0000, 16'h12EF, 1'b0, 2);
    issue("brd_hi",    1'b0, 1'b1, 16'h0201, 16'h0000, 16'h0012, 1'b0, 2);
    issue("brd_lo",    1'b0, 1'b1, 16'h0200, 16'h0000, 16'h00EF, 1'b0, 2);
    issue("wr_odd",    1'b1, 1'b0, 16'h0203, 16'h1234, 16'h00EF, 1'b0, 2);
    issue("rd_even",   1'b0, 1'b0, 16'h0202, 16'h0000, 16'h1234, 1'b0, 2);
    issue("rd_below",  1'b0, 1'b0, 16'h01FF, 16'h0000, 16'h0000, 1'b1, 1);
    issue("wr_above",  1'b1, 1'b0, 16'h0600, 16'hFFFF, 16'h0000, 1'b1, 1);
    issue("rd_noalias",1'b0, 1'b0, 16'h0200, 16'h0000, 16'h12EF, 1'b0, 2);
    issue("wr_top",    1'b1, 1'b0, 16'h05FE, 16'h5A5A, 16'h12EF, 1'b0, 2);
    issue("rd_top",    1'b0, 1'b0, 16'h05FF, 16'h0000, 16'h5A5A, 1'b0, 2);
    issue("brd_top",   1'b0, 1'b1, 16'h05FF, 16'h0000, 16'h005A, 1'b0, 2);
    issue("rd_zero",   1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1);
    issue("bwr_top",   1'b1, 1'b1, 16'h05FF, 16'h0034, 16'h0000, 1'b0, 4);

    // req held high with changing MAB while busy: only the first access runs.
    begin
      exp_t e;
      req = 1'b1; we = 1'b0; bw = 1'b0; MAB = 16'h0200;
      @(posedge clk);
      @(negedge clk);
      e.data = 16'h12EF; e.err = 1'b0; e.lat = 2; e.c0 = cyc; e.name = "rd_busy";
      sb.push_back(e);
      check("busy_high", 32'(busy), 32'd1);
      MAB = 16'h0202;
      @(posedge clk);
      @(negedge clk);
      MAB = 16'h05FE;
      @(posedge clk);
      @(negedge clk);
      check("busy_ready", 32'(ready), 32'd1);
      req = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("busy_no_extra", 32'(ready), 32'd0);
      end
    end
    issue("rd_after_busy", 1'b0, 1'b0, 16'h05FE, 16'h0000, 16'h345A, 1'b0, 2);

    // Reset during WR of a byte write must suppress the RAM write.
    issue("wr_pre_rst", 1'b1, 1'b0, 16'h0200, 16'h1234, 16'h345A, 1'b0, 2);
    req = 1'b1; we = 1'b1; bw = 1'b1; MAB = 16'h0200; MDB_in = 16'h00AA;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_mrg", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_ready", 32'(ready),   32'd0);
    check("abort_busy",  32'(busy),    32'd0);
    check("abort_err",   32'(err),     32'd0);
    check("abort_mdb",   32'(MDB_out), 32'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    issue("rd_post_rst",  1'b0, 1'b0, 16'h0200, 16'h0000, 16'h1234, 1'b0, 2);
    issue("brd_post_rst", 1'b0, 1'b1, 16'h0200, 16'h0000, 16'h0034, 1'b0, 2);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdb_mem_ctrl.md
# mdb_mem_ctrl

Data-memory controller on the memory data bus (MDB). It consumes the word selected by the MDB source multiplexer (`MDB_in`) and the memory address bus (`MAB`), performs word or byte reads and writes against an internal word-wide RAM, and returns read data on `MDB_out`, which feeds back into the same multiplexer. Byte writes are done as an internal read-modify-write, because the RAM has no byte enables. A req/ready handshake tells the control unit when an access has completed.

## Interface
- `ADDR_W`, default 9: RAM word-address width; the RAM has 2^ADDR_W words.
- `BASE`, default 16'h0200: first byte address decoded by the RAM. The valid range is `BASE` to `BASE + 2^(ADDR_W+1) - 1`, which is 0x0200–0x05FF at default.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  1  access request; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read.
- `bw`  in  1  1 = byte access, 0 = word access (MSP430 B/W sense).
- `MAB`  in  16  byte address.
- `MDB_in`  in  16  write data from the MDB mux. Byte writes use `[7:0]`.
- `MDB_out`  out  16  read data to the MDB mux. Registered; held until the next completed read.
- `ready`  out  1  one-cycle pulse when an access completes.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  pulses together with `ready` when the access was out of range.

## Operation
- **States:** IDLE, RD, MRG, WR, DONE.
- **Acceptance:** in IDLE, `req`=1 at a rising edge captures `MAB`, `MDB_in`, `we` and `bw` into holding registers. Later changes on these inputs are ignored until the access returns to IDLE.
- **Decode:** word index = (captured `MAB` − `BASE`) >> 1. Address bit 0 selects the byte lane for byte accesses and is ignored for word accesses.
- **Out of range:** IDLE → DONE with `err`=1. No RAM write occurs and `MDB_out` is loaded with 16'h0000.
- **Word read:** IDLE → RD → DONE.
  - RD issues the synchronous RAM read.
  - DONE loads `MDB_out`.
- **Byte read:** same path as a word read. `MDB_out` = {8'h00, selected byte}; lane 0 is `[7:0]`, lane 1 is `[15:8]`.
- **Word write:** IDLE → WR → DONE. WR writes the captured data to RAM.
- **Byte write:** IDLE → RD → MRG → WR → DONE.
  - RD reads the old word.
  - MRG replaces the selected lane with captured `MDB_in[7:0]`.
  - WR commits the merged word.
- **Writes and `MDB_out`:** writes never change `MDB_out`.
- **DONE:**
  - Asserts `ready` for exactly one cycle, then returns to IDLE.
  - A new `req` is accepted only on the edge after DONE, i.e. in IDLE.
  - `req` asserted while `busy` is ignored, not queued.
- **Reset:**
  - `rst_n`=0 at an edge forces IDLE, `MDB_out`=16'h0000, `ready`=0, `busy`=0 and `err`=0.
  - A RAM write that would occur on that same edge is suppressed.
  - RAM contents are not reset.

## Timing
- Edge E0 is the edge that accepts `req`.
- **Latency, `req` sample edge to `ready` high:**
  - word read: 2 cycles (`ready` and valid `MDB_out` after E2)
  - byte read: 2 cycles
  - word write: 2 cycles
  - byte write: 4 cycles
  - out of range: 1 cycle
- **Data timing:** `MDB_out` updates on the same edge that raises `ready`. The RAM write lands on the edge leaving WR.
- **Back-to-back:** minimum spacing between accepted requests is latency + 1 cycles.
- **Read-after-write:** a read accepted after a write's DONE sees the newly written data.
- **Boundaries:**
  - `BASE` and `BASE + 2^(ADDR_W+1) - 1` are in range.
  - `BASE` − 1 and `BASE + 2^(ADDR_W+1)` raise `err`.
  - Index arithmetic is 16-bit unsigned. Wrap-around below `BASE` must decode as out of range, never alias.

## Test plan
- **Word write/read:** write word 16'hBEEF at 0x0200, then word read at 0x0200 → `ready` 2 cycles after each req, `MDB_out`=16'hBEEF.
- **Byte merge:** with 0x0200 holding 16'hBEEF, byte write 0x12 at 0x0201 → `ready` after 4 cycles, word read 0x0200 = 16'h12EF. Byte read 0x0201 → 16'h0012; byte read 0x0200 → 16'h00EF.
- **Odd word address:** word write 16'h1234 at 0x0203, then word read 0x0202 → 16'h1234.
- **Range limits:**
  - read 0x01FF → `err`=`ready`=1 after 1 cycle, `MDB_out`=16'h0000.
  - write 0x0600 → `err`, no RAM change.
  - 0x05FE write/read round-trips.
- **Reset mid-access:** start byte write 0xAA at 0x0200 (old 16'h1234) and pull `rst_n` low in MRG or WR → all outputs 0, state IDLE, subsequent read 0x0200 = 16'h1234.
- **Busy handling:** assert `req` continuously with changing `MAB` during a word read → only the first access is performed, one `ready` per accepted req, next req accepted in IDLE.
